// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed leaky integrate-and-fire controller. One datapath sweeps N virtual
// neurons, one per cycle, on every accepted timestep tick.
module lif_sweep_scheduler #(
  parameter int unsigned N_NEURONS  = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned THRESHOLD  = 200,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRAC     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic [N_NEURONS*WIDTH-1:0]     cur_in,
  input  logic [N_NEURONS-1:0]           en_mask,
  input  logic [$clog2(N_NEURONS)-1:0]   sel,
  input  logic                           clr_ovr,
  output logic [WIDTH-1:0]               state_out,
  output logic [N_NEURONS-1:0]           spikes,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam int unsigned IW = $clog2(N_NEURONS);
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [WIDTH:0] ThrV = (WIDTH + 1)'(THRESHOLD);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              idx_q;
  logic [N_NEURONS*WIDTH-1:0] cur_q;
  logic [N_NEURONS-1:0]       en_q;
  logic [WIDTH-1:0]           mem_q [N_NEURONS];
  logic [RW-1:0]              ref_q [N_NEURONS];
  logic [N_NEURONS-1:0]       shadow_q, shadow_d;
  logic [N_NEURONS-1:0]       spikes_q;
  logic                       overrun_q;

  logic                       accept, last, ovr_set;
  logic [WIDTH-1:0]           cur_sel, s_cur, upd_s;
  logic [RW-1:0]              r_cur, upd_r;
  logic [WIDTH:0]             v;
  logic                       upd_spk;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    last    = (idx_q == IW'(N_NEURONS - 1));
    ovr_set = 1'b0;
    unique case (state_q)
      StIdle: accept = tick;
      StSweep: begin
        busy    = 1'b1;
        ovr_set = tick;
        if (last) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
        accept  = tick;
      end
      default: state_d = StIdle;
    endcase
    if (accept) state_d = StSweep;
  end

  // Shared neuron datapath for the neuron currently addressed by idx_q.
  always_comb begin
    cur_sel = cur_q[idx_q*WIDTH +: WIDTH];
    s_cur   = mem_q[idx_q];
    r_cur   = ref_q[idx_q];
    v       = {1'b0, s_cur} - ({1'b0, s_cur} >> LEAK_SHIFT) + {1'b0, cur_sel};
    upd_s   = s_cur;
    upd_r   = r_cur;
    upd_spk = 1'b0;
    if (en_q[idx_q]) begin
      if (r_cur != '0) begin
        upd_s = '0;
        upd_r = r_cur - RW'(1);
      end else if (v >= ThrV) begin
        upd_spk = 1'b1;
        upd_s   = '0;
        upd_r   = RW'(REFRAC);
      end else if (v[WIDTH]) begin
        upd_s = '1;
      end else begin
        upd_s = v[WIDTH-1:0];
      end
    end
    shadow_d        = shadow_q;
    shadow_d[idx_q] = upd_spk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cur_q     <= '0;
      en_q      <= '0;
      mem_q     <= '{default: '0};
      ref_q     <= '{default: '0};
      shadow_q  <= '0;
      spikes_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cur_q    <= cur_in;
        en_q     <= en_mask;
        idx_q    <= '0;
        shadow_q <= '0;
      end else if (state_q == StSweep) begin
        mem_q[idx_q] <= upd_s;
        ref_q[idx_q] <= upd_r;
        shadow_q     <= shadow_d;
        idx_q        <= idx_q + IW'(1);
        // Publish on the edge into DONE so spikes are valid alongside the done pulse.
        if (last) spikes_q <= shadow_d;
      end
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (sel == IW'(i)) state_out = mem_q[i];
    end
  end

  assign spikes  = spikes_q;
  assign overrun = overrun_q;

endmodule

// File: doc/lif_sweep_scheduler.md
Name: lif_sweep_scheduler

Overview:
- Time-multiplexed controller for an array of N leaky integrate-and-fire neurons that share one update datapath.
- On each timestep strobe it latches the per-neuron input currents and sequences a sweep, updating one neuron per cycle: leak, integrate, threshold, reset and refractory handling.
- Publishes the spike vector once per timestep.
- Sits between the top-level IO wrapper (switch inputs, bidirectional outputs) and the neuron state registers. It replaces per-neuron instantiation of the LIF datapath.

Parameters:
N_NEURONS, 4, number of virtual neurons sharing the datapath (2..16)
WIDTH, 8, membrane state and input current width, unsigned
THRESHOLD, 200, spike when post-integration value >= THRESHOLD (must be < 2^WIDTH)
LEAK_SHIFT, 1, leak term = state >> LEAK_SHIFT
REFRAC, 2, timesteps a neuron is held after a spike (0 disables)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
tick  input  1  timestep strobe, one-cycle pulse
cur_in  input  N_NEURONS*WIDTH  input currents; neuron i at bits [i*WIDTH +: WIDTH]
en_mask  input  N_NEURONS  per-neuron enable, sampled with cur_in
sel  input  clog2(N_NEURONS)  neuron selected for state readout
clr_ovr  input  1  clears the overrun flag
state_out  output  WIDTH  membrane state of neuron sel
spikes  output  N_NEURONS  spike vector of the last completed timestep
busy  output  1  sweep in progress
done  output  1  one-cycle pulse: timestep complete, spikes valid
overrun  output  1  sticky: tick arrived while busy

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset (any cycle, including mid-sweep):
  - FSM to IDLE.
  - All states, refractory counters, spikes, busy, done and overrun go to 0.
  - The partial sweep is abandoned and no done pulse is issued.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE or DONE with tick=1 in cycle t: latch cur_in and en_mask, idx<=0, go to SWEEP.
  - SWEEP: busy=1 during cycles t+1 .. t+N_NEURONS.
  - Neuron idx is updated at the edge ending cycle t+1+idx.
  - At idx = N_NEURONS-1, go to DONE.
  - DONE lasts one cycle (t+N_NEURONS+1): done=1, busy=0, spikes register updated (all bits simultaneously), then IDLE unless tick is accepted.
- tick in DONE is accepted; back-to-back timesteps need a period of N_NEURONS+1 cycles.
- tick while in SWEEP:
  - Ignored; the sweep is unaffected.
  - overrun<=1 and stays set until clr_ovr or rst.
  - If clr_ovr and an overrunning tick occur in the same cycle, set wins.
- Latched currents are used for the whole sweep; cur_in may change freely while busy.
- Per-neuron update, with s = stored state and c = latched current:
  - en_mask bit = 0: s and refractory counter unchanged; spike bit 0.
  - refractory counter > 0: s <= 0, counter decrements, current ignored, spike bit 0.
  - otherwise:
    - v = s - (s >> LEAK_SHIFT) + c, computed in WIDTH+1 bits.
    - If v >= THRESHOLD: spike bit 1, s <= 0, counter <= REFRAC.
    - Else s <= v, saturated to 2^WIDTH-1.
- Spike bits accumulate in a shadow register during the sweep and are copied to spikes in DONE. spikes holds until the next DONE or rst.
- state_out is a combinational mux of the stored state registers by sel. It reflects a neuron's new value from the cycle after its update edge.
- sel >= N_NEURONS: state_out = 0.

Test Plan:
- Integration to spike: N=4, TH=200, LEAK_SHIFT=1, REFRAC=2, neuron0 cur=100, others 0, all enabled, 8 ticks spaced 6 cycles -> neuron0 state after each tick 100,150,175,188,194,197,199, then tick 8 gives spikes=4'b0001 and state 0; other neurons stay 0.
- Refractory: continue the previous run for 3 more ticks -> ticks 9 and 10 give state 0 and spikes=0; tick 11 gives state 100.
- Timing: a tick accepted in cycle t -> busy high for exactly cycles t+1..t+4, done high only in t+5, spikes changes only in t+5; tick during DONE starts the next sweep with busy high at t+6.
- Overrun: tick at t+2 during a sweep -> sweep completes normally with unchanged results and overrun=1; clr_ovr pulse clears it; clr_ovr coinciding with another mid-sweep tick leaves overrun=1.
- Mask and latch: en_mask=4'b1101, cur=255 for all -> spikes=4'b1101 and neuron1 state unchanged; changing cur_in mid-sweep does not alter the results.
- Reset mid-sweep: rst at t+3 -> no done pulse; spikes, overrun and all states 0; busy=0 next cycle; the next tick produces a normal sweep.
